// File: rtl/medidor_periodo_multimodo.sv
// ============================================================================
//  Module      : medidor_periodo_multimodo
//  Description : Measures period, high time or low time of an asynchronous
//                square wave in clk cycles. Includes an input synchroniser,
//                timeout/overflow detection and optional averaging over
//                2^N_PROM measurements. Results are strobed by o_valid and
//                held on o_medida/o_ovf between strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module medidor_periodo_multimodo #(
    parameter int N_BITS = 16,
    parameter int N_SYNC = 2,
    parameter int N_PROM = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_senal,
    input  logic [1:0]        i_modo,
    output logic [N_BITS-1:0] o_medida,
    output logic              o_valid,
    output logic              o_ovf
);

    localparam int ACC_W   = N_BITS + N_PROM;
    localparam int BATCH_W = N_PROM + 1;

    localparam logic [N_BITS-1:0]  C_CNT_MAX    = '1;
    localparam logic [BATCH_W-1:0] C_BATCH_LAST = BATCH_W'((1 << N_PROM) - 1);
    localparam logic [1:0]         C_MODO_ALTO  = 2'b01;
    localparam logic [1:0]         C_MODO_BAJO  = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_MEDIR = 1'b1
    } estado_t;

    estado_t              r_estado;
    logic [N_SYNC-1:0]    r_sync;
    logic                 r_s_d;
    logic [1:0]           r_modo;
    logic [N_BITS-1:0]    r_cnt;
    logic [ACC_W-1:0]     r_acc;
    logic [BATCH_W-1:0]   r_lote;

    logic                 w_s;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_start;
    logic                 w_end;
    logic                 w_periodo;
    logic                 w_cambio;
    logic                 w_ultimo;
    logic [ACC_W-1:0]     w_suma;

    // Synchroniser chain for the asynchronous input
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N_SYNC-2:0], i_senal};
        end
    end

    // One-cycle delayed copy of the synchronised level for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= w_s;
        end
    end

    assign w_s    = r_sync[N_SYNC-1];
    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;

    // Low-time mode starts on a fall; high-time mode ends on a fall;
    // everything else (period, and the reserved code 11) uses rises.
    assign w_start   = (r_modo == C_MODO_BAJO) ? w_fall : w_rise;
    assign w_end     = (r_modo == C_MODO_ALTO) ? w_fall : w_rise;
    assign w_periodo = (r_modo != C_MODO_ALTO) && (r_modo != C_MODO_BAJO);
    assign w_cambio  = (i_modo != r_modo);

    // Running sum including the measurement that ends this cycle; the
    // averaged result is just the upper N_BITS of that sum.
    assign w_suma   = r_acc + ACC_W'(r_cnt);
    assign w_ultimo = (r_lote == C_BATCH_LAST);

    // Measurement FSM, averaging accumulator and registered result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= ST_IDLE;
            r_modo   <= 2'b00;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_lote   <= '0;
            o_medida <= '0;
            o_valid  <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            r_modo  <= i_modo;
            o_valid <= 1'b0;
            if (w_cambio) begin
                // A mode change discards any partial measurement or batch;
                // the previous result stays visible.
                r_estado <= ST_IDLE;
                r_cnt    <= '0;
                r_acc    <= '0;
                r_lote   <= '0;
            end else begin
                case (r_estado)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_cnt    <= N_BITS'(1);
                            r_estado <= ST_MEDIR;
                        end
                    end
                    ST_MEDIR: begin
                        if (w_end) begin
                            if (w_ultimo) begin
                                o_medida <= w_suma[ACC_W-1:N_PROM];
                                o_ovf    <= 1'b0;
                                o_valid  <= 1'b1;
                                r_acc    <= '0;
                                r_lote   <= '0;
                            end else begin
                                r_acc    <= w_suma;
                                r_lote   <= r_lote + 1'b1;
                            end
                            // In period mode the closing rise also opens
                            // the next measurement.
                            if (w_periodo) begin
                                r_cnt <= N_BITS'(1);
                            end else begin
                                r_estado <= ST_IDLE;
                            end
                        end else if (r_cnt == C_CNT_MAX) begin
                            o_medida <= C_CNT_MAX;
                            o_ovf    <= 1'b1;
                            o_valid  <= 1'b1;
                            r_acc    <= '0;
                            r_lote   <= '0;
                            r_estado <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_estado <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_medidor_periodo_multimodo.sv
// ============================================================================
//  Module      : tb_medidor_periodo_multimodo
//  Description : Self-checking bench for medidor_periodo_multimodo. Two
//                instances (no averaging / 4-sample averaging) are driven
//                with directed and random square waves; results are compared
//                against an edge-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_medidor_periodo_multimodo;

    localparam int NB     = 8;
    localparam int SYNC_A = 2;
    localparam int PROM_A = 0;
    localparam int SYNC_B = 3;
    localparam int PROM_B = 2;
    localparam int MAXC   = (1 << NB) - 1;

    typedef struct { int t; bit lvl; } ev_t;
    typedef struct { int t; int val; bit ovf; } res_t;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          senal_a = 1'b0;
    logic          senal_b = 1'b0;
    logic [1:0]    modo_a  = 2'b00;
    logic [1:0]    modo_b  = 2'b00;
    logic [NB-1:0] medida_a, medida_b;
    logic          valid_a, valid_b, ovf_a, ovf_b;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   lvl_a  = 1'b0;
    bit   lvl_b  = 1'b0;
    ev_t  ev_a[$];
    ev_t  ev_b[$];
    res_t got_a[$];
    res_t got_b[$];
    res_t exp_q[$];
    res_t mon_a, mon_b;

    medidor_periodo_multimodo #(.N_BITS(NB), .N_SYNC(SYNC_A), .N_PROM(PROM_A)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .i_senal  (senal_a),
        .i_modo   (modo_a),
        .o_medida (medida_a),
        .o_valid  (valid_a),
        .o_ovf    (ovf_a)
    );

    medidor_periodo_multimodo #(.N_BITS(NB), .N_SYNC(SYNC_B), .N_PROM(PROM_B)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .i_senal  (senal_b),
        .i_modo   (modo_b),
        .o_medida (medida_b),
        .o_valid  (valid_b),
        .o_ovf    (ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every strobe with its cycle index (sampled on the falling edge)
    always @(negedge clk) begin
        if (valid_a === 1'b1) begin
            mon_a.t = cyc; mon_a.val = int'(medida_a); mon_a.ovf = ovf_a;
            got_a.push_back(mon_a);
        end
        if (valid_b === 1'b1) begin
            mon_b.t = cyc; mon_b.val = int'(medida_b); mon_b.ovf = ovf_b;
            got_b.push_back(mon_b);
        end
    end

    // Drive one level on channel ch for n cycles, logging real pin edges
    task automatic seg(input bit ch, input bit v, input int n);
        ev_t e;
        @(negedge clk);
        e.t = cyc; e.lvl = v;
        if (ch == 1'b0) begin
            senal_a = v;
            if (v != lvl_a) begin ev_a.push_back(e); lvl_a = v; end
        end else begin
            senal_b = v;
            if (v != lvl_b) begin ev_b.push_back(e); lvl_b = v; end
        end
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] ma, input logic [1:0] mb);
        @(negedge clk);
        senal_a = 1'b0; senal_b = 1'b0; lvl_a = 1'b0; lvl_b = 1'b0;
        modo_a = ma; modo_b = mb;
        repeat (SYNC_B + 3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        got_a.delete(); got_b.delete(); ev_a.delete(); ev_b.delete(); exp_q.delete();
    endtask

    // Reference model: walks the list of pin edges. A pin edge logged at
    // cycle t is seen by the measuring logic nsync cycles later and its
    // result strobe is visible one cycle after that (t + nsync + 1).
    // A measurement runs out when it would exceed MAXC cycles; the overflow
    // strobe then appears MAXC+1 cycles after the starting edge was seen.
    task automatic model(input ev_t ev[$], input int mode, input int nsync,
                         input int nprom, input int end_t);
        int   m, start, acc, n, d;
        bit   meas, st, en;
        res_t r;
        m = (mode == 3) ? 0 : mode;
        meas = 1'b0; start = 0; acc = 0; n = 0;
        foreach (ev[i]) begin
            if (meas && (ev[i].t - start > MAXC)) begin
                r.t = start + nsync + MAXC + 1; r.val = MAXC; r.ovf = 1'b1;
                exp_q.push_back(r);
                meas = 1'b0; acc = 0; n = 0;
            end
            st = (m == 2) ? !ev[i].lvl : ev[i].lvl;
            en = (m == 1) ? !ev[i].lvl : ev[i].lvl;
            if (meas && en) begin
                d = ev[i].t - start;
                acc += d;
                n++;
                if (n == (1 << nprom)) begin
                    r.t = ev[i].t + nsync + 1; r.val = acc >> nprom; r.ovf = 1'b0;
                    exp_q.push_back(r);
                    acc = 0; n = 0;
                end
                if (m == 0) start = ev[i].t;
                else        meas  = 1'b0;
            end else if (!meas && st) begin
                meas  = 1'b1;
                start = ev[i].t;
            end
        end
        if (meas && (start + nsync + MAXC + 1 <= end_t)) begin
            r.t = start + nsync + MAXC + 1; r.val = MAXC; r.ovf = 1'b1;
            exp_q.push_back(r);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (medida_a !== '0 || valid_a !== 1'b0 || ovf_a !== 1'b0 ||
            medida_b !== '0 || valid_b !== 1'b0 || ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: a=%0d/%b/%b b=%0d/%b/%b, expected all zero",
                     medida_a, valid_a, ovf_a, medida_b, valid_b, ovf_b);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (medida_a !== '0 || valid_a !== 1'b0 || ovf_a !== 1'b0 ||
            medida_b !== '0 || valid_b !== 1'b0 || ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: a=%0d/%b/%b b=%0d/%b/%b, expected all zero",
                     medida_a, valid_a, ovf_a, medida_b, valid_b, ovf_b);
        end
    endtask

    task automatic test_period(input logic [1:0] md);
        int end_t;
        do_reset(md, 2'b00);
        repeat (8) begin seg(0, 1, 10); seg(0, 0, 10); end
        repeat (8) @(negedge clk);
        @(posedge clk); end_t = cyc;
        model(ev_a, int'(md), SYNC_A, PROM_A, end_t);
        checks++;
        if (got_a.size() !== 7) begin
            errors++; $display("FAIL period_count mode=%0d: got %0d, expected 7", md, got_a.size());
        end
        foreach (got_a[i]) begin
            checks++;
            if (got_a[i].val !== 20 || got_a[i].ovf !== 1'b0) begin
                errors++;
                $display("FAIL period_val[%0d]: got %0d ovf=%0d, expected 20 ovf=0", i, got_a[i].val, got_a[i].ovf);
            end
        end
        checks++;
        if (got_a.size() !== exp_q.size()) begin
            errors++; $display("FAIL period_model_count: got %0d, expected %0d", got_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i].t !== exp_q[i].t || got_a[i].val !== exp_q[i].val || got_a[i].ovf !== exp_q[i].ovf) begin
                errors++;
                $display("FAIL period_model[%0d]: got t=%0d v=%0d o=%0d, expected t=%0d v=%0d o=%0d",
                         i, got_a[i].t, got_a[i].val, got_a[i].ovf, exp_q[i].t, exp_q[i].val, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_duty(input logic [1:0] md, input int want, input int want_n);
        int end_t;
        do_reset(md, 2'b00);
        repeat (5) begin seg(0, 1, 6); seg(0, 0, 14); end
        repeat (8) @(negedge clk);
        @(posedge clk); end_t = cyc;
        model(ev_a, int'(md), SYNC_A, PROM_A, end_t);
        checks++;
        if (got_a.size() !== want_n) begin
            errors++; $display("FAIL duty_count mode=%0d: got %0d, expected %0d", md, got_a.size(), want_n);
        end
        foreach (got_a[i]) begin
            checks++;
            if (got_a[i].val !== want || got_a[i].ovf !== 1'b0) begin
                errors++;
                $display("FAIL duty_val[%0d] mode=%0d: got %0d, expected %0d", i, md, got_a[i].val, want);
            end
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i].t !== exp_q[i].t) begin
                errors++; $display("FAIL duty_time[%0d]: got t=%0d, expected t=%0d", i, got_a[i].t, exp_q[i].t);
            end
        end
    endtask

    task automatic test_average();
        int end_t;
        int per[4] = '{20, 24, 28, 32};
        // Periods 10, 11, 10, 11 -> one result of 42 >> 2 = 10
        do_reset(2'b00, 2'b00);
        repeat (2) begin seg(1, 1, 5); seg(1, 0, 5); seg(1, 1, 5); seg(1, 0, 6); end
        seg(1, 1, 5); seg(1, 0, 5);
        repeat (8) @(negedge clk);
        checks++;
        if (got_b.size() !== 1) begin
            errors++; $display("FAIL avg_count: got %0d, expected 1", got_b.size());
        end else begin
            checks++;
            if (got_b[0].val !== 10 || got_b[0].ovf !== 1'b0) begin
                errors++; $display("FAIL avg_val: got %0d ovf=%0d, expected 10 ovf=0", got_b[0].val, got_b[0].ovf);
            end
        end
        // Two measurements, then a timeout that must drop the partial batch
        do_reset(2'b00, 2'b00);
        repeat (2) begin seg(1, 1, 6); seg(1, 0, 6); end
        seg(1, 1, 6); seg(1, 0, 300);
        foreach (per[i]) begin seg(1, 1, 10); seg(1, 0, per[i] - 10); end
        seg(1, 1, 5); seg(1, 0, 5);
        repeat (8) @(negedge clk);
        @(posedge clk); end_t = cyc;
        model(ev_b, 0, SYNC_B, PROM_B, end_t);
        checks++;
        if (got_b.size() !== exp_q.size() || got_b.size() !== 2) begin
            errors++; $display("FAIL avg_to_count: got %0d, expected %0d", got_b.size(), exp_q.size());
        end else begin
            checks++;
            if (got_b[0].val !== MAXC || got_b[0].ovf !== 1'b1 || got_b[1].val !== 26 || got_b[1].ovf !== 1'b0) begin
                errors++;
                $display("FAIL avg_to_val: got %0d/%0d %0d/%0d, expected 255/1 26/0",
                         got_b[0].val, got_b[0].ovf, got_b[1].val, got_b[1].ovf);
            end
        end
        for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i].t !== exp_q[i].t || got_b[i].val !== exp_q[i].val || got_b[i].ovf !== exp_q[i].ovf) begin
                errors++;
                $display("FAIL avg_model[%0d]: got t=%0d v=%0d o=%0d, expected t=%0d v=%0d o=%0d",
                         i, got_b[i].t, got_b[i].val, got_b[i].ovf, exp_q[i].t, exp_q[i].val, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_timeout();
        int end_t;
        int want_v[6] = '{255, 30, 25, 255, 255, 20};
        bit want_o[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset(2'b00, 2'b00);
        seg(0, 1, 10); seg(0, 0, 300);                   // lone rise -> overflow
        seg(0, 1, 15); seg(0, 0, 15); seg(0, 1, 15); seg(0, 0, 10);
        seg(0, 1, 100); seg(0, 0, 155);                  // exactly 255: normal
        seg(0, 1, 100); seg(0, 0, 156);                  // 256: overflow
        seg(0, 1, 10); seg(0, 0, 10); seg(0, 1, 5); seg(0, 0, 5);
        repeat (8) @(negedge clk);
        @(posedge clk); end_t = cyc;
        model(ev_a, 0, SYNC_A, PROM_A, end_t);
        checks++;
        if (got_a.size() !== 6) begin
            errors++; $display("FAIL timeout_count: got %0d, expected 6", got_a.size());
        end
        for (int i = 0; i < 6 && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i].val !== want_v[i] || got_a[i].ovf !== want_o[i]) begin
                errors++;
                $display("FAIL timeout_val[%0d]: got %0d ovf=%0d, expected %0d ovf=%0d",
                         i, got_a[i].val, got_a[i].ovf, want_v[i], want_o[i]);
            end
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i].t !== exp_q[i].t) begin
                errors++; $display("FAIL timeout_time[%0d]: got t=%0d, expected t=%0d", i, got_a[i].t, exp_q[i].t);
            end
        end
    endtask

    task automatic test_mode_change();
        ev_t pre[$];
        ev_t post[$];
        int  tc, end_t;
        do_reset(2'b00, 2'b00);
        repeat (4) begin seg(0, 1, 7); seg(0, 0, 13); end
        seg(0, 1, 5);
        @(negedge clk); modo_a = 2'b01; tc = cyc;
        @(negedge clk);
        seg(0, 0, 13); seg(0, 1, 7);
        checks++;
        if (medida_a !== 8'd20 || ovf_a !== 1'b0) begin
            errors++; $display("FAIL mode_hold: got %0d ovf=%0d, expected 20 ovf=0", medida_a, ovf_a);
        end
        seg(0, 0, 13); seg(0, 1, 7); seg(0, 0, 13);
        repeat (6) @(negedge clk);
        @(posedge clk); end_t = cyc;
        foreach (ev_a[i]) begin
            if (ev_a[i].t < tc) pre.push_back(ev_a[i]);
            else                post.push_back(ev_a[i]);
        end
        // The abort makes everything after the change a fresh start
        model(pre, 0, SYNC_A, PROM_A, tc);
        model(post, 1, SYNC_A, PROM_A, end_t);
        checks++;
        if (got_a.size() !== exp_q.size() || got_a.size() !== 6) begin
            errors++; $display("FAIL mode_count: got %0d, expected %0d", got_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i].t !== exp_q[i].t || got_a[i].val !== exp_q[i].val || got_a[i].ovf !== exp_q[i].ovf) begin
                errors++;
                $display("FAIL mode_model[%0d]: got t=%0d v=%0d o=%0d, expected t=%0d v=%0d o=%0d",
                         i, got_a[i].t, got_a[i].val, got_a[i].ovf, exp_q[i].t, exp_q[i].val, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_reset_mid();
        int end_t;
        do_reset(2'b00, 2'b00);
        repeat (2) begin seg(0, 1, 10); seg(0, 0, 10); end
        seg(0, 1, 10); seg(0, 0, 4);
        checks++;
        if (medida_a !== 8'd20) begin
            errors++; $display("FAIL rstmid_pre: got %0d, expected 20", medida_a);
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        checks++;
        if (medida_a !== '0 || ovf_a !== 1'b0 || valid_a !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear: got %0d ovf=%0d valid=%0d, expected 0/0/0", medida_a, ovf_a, valid_a);
        end
        got_a.delete(); ev_a.delete(); exp_q.delete();
        repeat (6) @(negedge clk);
        seg(0, 1, 10); seg(0, 0, 10);
        checks++;
        if (medida_a !== '0 || got_a.size() !== 0) begin
            errors++; $display("FAIL rstmid_first_edge: got %0d with %0d strobes, expected 0 with 0", medida_a, got_a.size());
        end
        seg(0, 1, 10); seg(0, 0, 10); seg(0, 1, 10); seg(0, 0, 10);
        repeat (6) @(negedge clk);
        @(posedge clk); end_t = cyc;
        model(ev_a, 0, SYNC_A, PROM_A, end_t);
        checks++;
        if (got_a.size() !== exp_q.size()) begin
            errors++; $display("FAIL rstmid_count: got %0d, expected %0d", got_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i].t !== exp_q[i].t || got_a[i].val !== exp_q[i].val || got_a[i].ovf !== exp_q[i].ovf) begin
                errors++;
                $display("FAIL rstmid_model[%0d]: got t=%0d v=%0d o=%0d, expected t=%0d v=%0d o=%0d",
                         i, got_a[i].t, got_a[i].val, got_a[i].ovf, exp_q[i].t, exp_q[i].val, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_random(input bit ch, input int rounds);
        int         end_t, nseg, len;
        logic [1:0] md;
        bit         v;
        for (int r = 0; r < rounds; r++) begin
            md = 2'($urandom_range(0, 3));
            if (ch == 1'b0) do_reset(md, 2'b00);
            else            do_reset(2'b00, md);
            nseg = $urandom_range(12, 30);
            v    = 1'b1;
            for (int s = 0; s < nseg; s++) begin
                if ($urandom_range(0, 11) == 0) len = $urandom_range(240, 270);
                else                            len = $urandom_range(1, 40);
                seg(ch, v, len);
                v = ~v;
            end
            repeat (8) @(negedge clk);
            @(posedge clk); end_t = cyc;
            if (ch == 1'b0) begin
                model(ev_a, int'(md), SYNC_A, PROM_A, end_t);
                checks++;
                if (got_a.size() !== exp_q.size()) begin
                    errors++; $display("FAIL rand_a_count r=%0d mode=%0d: got %0d, expected %0d", r, md, got_a.size(), exp_q.size());
                end
                for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
                    checks++;
                    if (got_a[i].t !== exp_q[i].t || got_a[i].val !== exp_q[i].val || got_a[i].ovf !== exp_q[i].ovf) begin
                        errors++;
                        $display("FAIL rand_a[%0d] mode=%0d: got t=%0d v=%0d o=%0d, expected t=%0d v=%0d o=%0d",
                                 i, md, got_a[i].t, got_a[i].val, got_a[i].ovf, exp_q[i].t, exp_q[i].val, exp_q[i].ovf);
                    end
                end
            end else begin
                model(ev_b, int'(md), SYNC_B, PROM_B, end_t);
                checks++;
                if (got_b.size() !== exp_q.size()) begin
                    errors++; $display("FAIL rand_b_count r=%0d mode=%0d: got %0d, expected %0d", r, md, got_b.size(), exp_q.size());
                end
                for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
                    checks++;
                    if (got_b[i].t !== exp_q[i].t || got_b[i].val !== exp_q[i].val || got_b[i].ovf !== exp_q[i].ovf) begin
                        errors++;
                        $display("FAIL rand_b[%0d] mode=%0d: got t=%0d v=%0d o=%0d, expected t=%0d v=%0d o=%0d",
                                 i, md, got_b[i].t, got_b[i].val, got_b[i].ovf, exp_q[i].t, exp_q[i].val, exp_q[i].ovf);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_period(2'b00);
        test_period(2'b11);
        test_duty(2'b01, 6, 5);
        test_duty(2'b10, 14, 4);
        test_average();
        test_timeout();
        test_mode_change();
        test_reset_mid();
        test_random(1'b0, 6);
        test_random(1'b1, 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
